// File: rtl/uart_pkg.sv
// UART receiver shared types: FSM state encoding, default bit period, parity helper.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a reset line reads as idle.
module bit_synchronizer (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/(parity)/stop FSM with mid-bit sampling.
// Define UART_RX_PARITY_EN for one even-parity bit after the data.
import uart_pkg::*;

module uart_rx #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WORD_LENGTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rx,
  output logic [WORD_LENGTH-1:0] data,
  output logic                   valid,
  output logic                   frame_error,
  output logic                   parity_error,
  output logic                   busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BLAST = BW'(WORD_LENGTH - 1);

  logic rx_s;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WORD_LENGTH-1:0] sh_q, sh_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                 rx_prev_q, rx_prev_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 ppend_q, ppend_d;
  logic                 perr_q, perr_d;
`endif

  bit_synchronizer u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    data_d    = data_q;
    rx_prev_d = rx_s;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    ppend_d   = ppend_q;
    perr_d    = 1'b0;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          bit_d = '0;
          // only a genuine 1->0 transition starts a frame
          if (rx_prev_q && !rx_s)
            state_d = ST_START;
        end
        ST_START: begin
          if (cnt_q == HALF) begin
            cnt_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            sh_d  = {rx_s, sh_q[WORD_LENGTH-1:1]};
            if (bit_q == BLAST) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            ppend_d = even_parity(32'(sh_q)) ^ rx_s;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            data_d  = sh_q;
            valid_d = rx_s;
            ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = ppend_q;
            ppend_d = 1'b0;
`endif
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      rx_prev_q <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ppend_q   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      rx_prev_q <= rx_prev_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      ppend_q   <= ppend_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit, 8 data bits.
// Define UART_RX_PARITY_EN to also exercise the parity frames.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  typedef struct {
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .WORD_LENGTH  (8)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .enable       (enable),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input logic par);
    exp_t e;
    e.v  = stop;
    e.fe = !stop;
`ifdef UART_RX_PARITY_EN
    e.pe = par ^ (^d);
`else
    e.pe = 1'b0;
`endif
    e.d  = d;
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  // monitor: every output pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (valid || frame_error || parity_error)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {valid, frame_error, parity_error}, 3'b000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid", valid, e.v);
        chk("frame_error", frame_error, e.fe);
        chk("parity_error", parity_error, e.pe);
        chk("data", data, e.d);
      end
    end
  end

  initial begin
    // reset state
    cycles(3);
    @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", frame_error, 1'b0);
    chk("rst_perr", parity_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    cycles(CPB);

    // good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    cycles(4);
    @(negedge clk);
    chk("a5_busy", busy, 1'b0);
    chk("a5_data", data, 8'hA5);
    chk("a5_sb_empty", sb.size(), 0);
    cycles(CPB);

    // stop bit low, then a held-low line must not retrigger
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    cycles(100);
    @(negedge clk);
    chk("break_busy", busy, 1'b0);
    chk("3c_data", data, 8'h3C);
    rx = 1'b1;
    cycles(2 * CPB);

    // 4-cycle glitch
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", busy, 1'b1);
    cycles(20);
    @(negedge clk);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("glitch_data", data, 8'h3C);

    // enable drop mid 0xFF
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    enable = 1'b0;
    cycles(2);
    @(negedge clk);
    chk("en_busy", busy, 1'b0);
    chk("en_data", data, 8'h3C);
    enable = 1'b1;
    cycles(8 * CPB);

    // reset mid 0xFF
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    cycles(2);
    @(negedge clk);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_data", data, 8'h00);
    rst_n = 1'b1;
    cycles(8 * CPB);

    send_frame(8'h12, 1'b1, 1'b0);
    cycles(CPB);
    chk("12_data", data, 8'h12);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    cycles(CPB);
    send_frame(8'h07, 1'b1, 1'b0);
    cycles(CPB);
`endif

    // back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0);
    cycles(2 * CPB);
    @(negedge clk);
    chk("b2b_data", data, 8'h55);
    chk("b2b_busy", busy, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
